// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   8-phase instruction controller for the lab CPU. A 3-bit phase counter
//   steps through fetch (P0-P3) and execute (P4-P7); the control strobes are a
//   purely combinational decode of (phase, opcode, zero, halted), so they are
//   valid in the same cycle as the phase they belong to. HLT latches a halted
//   flag that freezes the phase counter until reset.
//
// Ports
//   clk     in   system clock, all state changes on posedge
//   rst_    in   asynchronous reset, active low
//   opcode  in   [2:0] opcode from the instruction register
//   zero    in   accumulator-is-zero flag
//   sel     out  address mux select (1 = PC, 0 = IR operand address)
//   rd      out  memory read enable
//   ld_ir   out  load instruction register
//   inc_pc  out  increment program counter
//   halt    out  machine halted
//   ld_pc   out  load program counter (jump)
//   data_e  out  drive data bus from accumulator
//   ld_ac   out  load accumulator
//   wr      out  memory write strobe
//   phase   out  [2:0] current phase number
// -----------------------------------------------------------------------------
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    P_INST_ADDR  = 3'd0,
    P_INST_FETCH = 3'd1,
    P_INST_LOAD  = 3'd2,
    P_IDLE       = 3'd3,
    P_OP_ADDR    = 3'd4,
    P_OP_FETCH   = 3'd5,
    P_ALU_OP     = 3'd6,
    P_STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t r_phase;
  logic   r_halted;
  phase_t w_phase_next;
  logic   w_halted_next;
  logic   w_aluop;

  // State register. Once halted, the phase is frozen; only reset clears it.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_phase  <= P_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_next;
      r_halted <= w_halted_next;
    end
  end

  // Next state plus output decode.
  always_comb begin
    w_phase_next  = r_phase;
    w_halted_next = r_halted;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;

    w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
              (opcode == OP_XOR) || (opcode == OP_LDA);

    if (!r_halted) begin
      w_phase_next = phase_t'(r_phase + 3'd1);
      // The counter still advances out of P4 on the edge that sets halted,
      // so a halted machine rests in P5.
      if (r_phase == P_OP_ADDR && opcode == OP_HLT) begin
        w_halted_next = 1'b1;
      end
    end

    // Reset masks the decode as well, otherwise P0 would show sel=1 while
    // rst_ is held low.
    if (!rst_) begin
      // all strobes stay 0
    end else if (r_halted) begin
      halt = 1'b1;
    end else begin
      unique case (r_phase)
        P_INST_ADDR: begin
          sel = 1'b1;
        end
        P_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        P_INST_LOAD, P_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        P_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        P_OP_FETCH: begin
          rd = w_aluop;
        end
        P_ALU_OP: begin
          rd     = w_aluop;
          // A second PC increment skips the next instruction.
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        P_STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: begin
        end
      endcase
    end
  end

  assign phase = r_phase;

endmodule
